// File: rtl/shift_pipe_pkg.sv
// Shared types and helpers for the parametrised shift pipeline.
// Optional parity storage is enabled by SHIFT_PIPE_PARITY_EN.
package shift_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Select fields need at least one bit even for tiny pipes
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 par;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/param_shift_pipe_if.sv
// Producer/consumer bundle for param_shift_pipe.
// Port list is the same with or without SHIFT_PIPE_PARITY_EN.
interface param_shift_pipe_if #(
    parameter int WIDTH = shift_pipe_pkg::DEF_WIDTH,
    parameter int DEPTH = shift_pipe_pkg::DEF_DEPTH
);
    import shift_pipe_pkg::*;

    localparam int TAPW = clog2_min1(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic            En;
    logic            Flush;
    logic [WIDTH-1:0] D;
    logic            DValid;
    logic [TAPW-1:0] TapSel;
    logic [WIDTH-1:0] Q;
    logic            QValid;
    logic [WIDTH-1:0] TapQ;
    logic            TapValid;
    logic [CNTW-1:0] Count;
    logic            Full;
    logic            Empty;
    logic            ParErr;

    modport master (
        output En, Flush, D, DValid, TapSel,
        input  Q, QValid, TapQ, TapValid,
        input  Count, Full, Empty, ParErr
    );

    modport slave (
        input  En, Flush, D, DValid, TapSel,
        output Q, QValid, TapQ, TapValid,
        output Count, Full, Empty, ParErr
    );

endinterface

// File: rtl/shift_pipe_stage.sv
// One registered stage: data, valid and (optionally) parity.
// Parity storage exists only with SHIFT_PIPE_PARITY_EN.
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic             prev_par,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid_q,
    output logic             par_q,
    output logic [WIDTH-1:0] data_q
);

    // Flush drops validity only; data is kept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= prev_valid;
            data_q  <= prev_data;
        end
    end

`ifdef SHIFT_PIPE_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (!flush && en) begin
            par_q <= prev_par;
        end
    end
`else
    logic unused_par;
    assign unused_par = prev_par;
    assign par_q      = 1'b0;
`endif

endmodule

// File: rtl/param_shift_pipe.sv
// WIDTH x DEPTH shift pipe with valid tracking, stall, flush, tap, count.
// SHIFT_PIPE_PARITY_EN adds per-stage parity and sticky ParErr.
module param_shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic Clock,
    input  logic Resetn,
    param_shift_pipe_if.slave bus
);

    localparam int TAPW = clog2_min1(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] sdata  [DEPTH];
    logic             svalid [DEPTH];
    logic             spar   [DEPTH];
    logic [WIDTH-1:0] pdata  [DEPTH];
    logic             pvalid [DEPTH];
    logic             ppar   [DEPTH];

    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] tap_d;
    logic             tap_v;
    logic             parerr;

    assign pdata[0]  = bus.D;
    assign pvalid[0] = bus.DValid;
    assign ppar[0]   = ^bus.D;

    for (genvar i = 1; i < DEPTH; i++) begin : g_link
        assign pdata[i]  = sdata[i-1];
        assign pvalid[i] = svalid[i-1];
        assign ppar[i]   = spar[i-1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        shift_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (Clock),
            .rst_n     (Resetn),
            .en        (bus.En),
            .flush     (bus.Flush),
            .prev_valid(pvalid[i]),
            .prev_par  (ppar[i]),
            .prev_data (pdata[i]),
            .valid_q   (svalid[i]),
            .par_q     (spar[i]),
            .data_q    (sdata[i])
        );
    end

    // Entry and exit in one shift cancel out
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count <= '0;
        end else if (bus.Flush) begin
            count <= '0;
        end else if (bus.En) begin
            count <= count + CNTW'(bus.DValid)
                           - CNTW'(svalid[DEPTH-1]);
        end
    end

    always_comb begin
        tap_d = '0;
        tap_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.TapSel == TAPW'(i)) begin
                tap_d = sdata[i];
                tap_v = svalid[i];
            end
        end
    end

`ifdef SHIFT_PIPE_PARITY_EN
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            parerr <= 1'b0;
        end else if (svalid[DEPTH-1] &&
                     ((^sdata[DEPTH-1]) != spar[DEPTH-1])) begin
            parerr <= 1'b1;
        end
    end
`else
    logic unused_spar;
    assign unused_spar = spar[DEPTH-1];
    assign parerr      = 1'b0;
`endif

    assign bus.Q        = sdata[DEPTH-1];
    assign bus.QValid   = svalid[DEPTH-1];
    assign bus.TapQ     = tap_d;
    assign bus.TapValid = tap_v;
    assign bus.Count    = count;
    assign bus.Full     = (count == CNTW'(DEPTH));
    assign bus.Empty    = (count == '0);
    assign bus.ParErr   = parerr;

endmodule

// File: tb/tb_param_shift_pipe.sv
// Table-driven bench with an in-order scoreboard for param_shift_pipe.
// Parity checks run when SHIFT_PIPE_PARITY_EN is defined.
module tb_param_shift_pipe;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    param_shift_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();
    param_shift_pipe_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

    param_shift_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus.slave)
    );

    param_shift_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus3.slave)
    );

    typedef struct {
        bit       rst;
        bit       en;
        bit       fl;
        bit       dv;
        bit [7:0] d;
        bit [1:0] ts;
        bit [7:0] q;
        bit       qv;
        bit [7:0] tq;
        bit       tv;
        int       cnt;
    } vec_t;

    vec_t     vecs[$];
    bit [7:0] sb[$];
    int       total = 0;
    int       bad   = 0;
    int       row   = -1;

    function automatic void add(bit rst, bit en, bit fl, bit dv,
                                bit [7:0] d, bit [1:0] ts,
                                bit [7:0] q, bit qv,
                                bit [7:0] tq, bit tv, int cnt);
        vec_t r;
        r.rst = rst; r.en = en; r.fl = fl; r.dv = dv;
        r.d = d; r.ts = ts; r.q = q; r.qv = qv;
        r.tq = tq; r.tv = tv; r.cnt = cnt;
        vecs.push_back(r);
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h",
                     nm, row, act, exp);
        end
    endtask

    // Drive one cycle; scoreboard sees the word leaving before the edge
    task automatic step(bit rst, bit en, bit fl, bit dv,
                        bit [7:0] d, bit [1:0] ts);
        Resetn     = !rst;
        bus.En     = en;
        bus.Flush  = fl;
        bus.DValid = dv;
        bus.D      = d;
        bus.TapSel = ts;
        #1;
        if (rst || fl) begin
            sb.delete();
        end else if (en) begin
            if (bus.QValid) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    chk("sb_q", bus.Q, sb.pop_front());
                end
            end
            if (dv) sb.push_back(d);
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        bus.En = 0; bus.Flush = 0; bus.D = 0;
        bus.DValid = 0; bus.TapSel = 0;
        bus3.En = 0; bus3.Flush = 0; bus3.D = 0;
        bus3.DValid = 0; bus3.TapSel = 0;

        add(1,0,0,0,8'h00,0, 8'h00,0,8'h00,0,0);
        // streaming fill
        add(0,1,0,1,8'h11,0, 8'h00,0,8'h11,1,1);
        add(0,1,0,1,8'h22,0, 8'h00,0,8'h22,1,2);
        add(0,1,0,1,8'h33,0, 8'h00,0,8'h33,1,3);
        add(0,1,0,1,8'h44,0, 8'h11,1,8'h44,1,4);
        add(0,1,0,1,8'h55,0, 8'h22,1,8'h55,1,4);
        // stall then drain with bubbles
        for (int i = 0; i < 3; i++)
            add(0,0,0,1,8'hEE,2, 8'h22,1,8'h33,1,4);
        add(0,1,0,0,8'h00,2, 8'h33,1,8'h44,1,3);
        add(0,1,0,0,8'h00,2, 8'h44,1,8'h55,1,2);
        add(0,1,0,0,8'h00,2, 8'h55,1,8'h00,0,1);
        add(0,1,0,0,8'h00,2, 8'h00,0,8'h00,0,0);
        // alternating valid
        add(0,1,0,1,8'hA1,1, 8'h00,0,8'h00,0,1);
        add(0,1,0,0,8'hB2,1, 8'h00,0,8'hA1,1,1);
        add(0,1,0,1,8'hC3,1, 8'h00,0,8'hB2,0,2);
        add(0,1,0,0,8'hD4,1, 8'hA1,1,8'hC3,1,2);
        add(0,1,0,1,8'hE5,1, 8'hB2,0,8'hD4,0,2);
        add(0,1,0,0,8'hF6,1, 8'hC3,1,8'hE5,1,2);
        add(0,1,0,1,8'h07,1, 8'hD4,0,8'hF6,0,2);
        // fill, flush with a live word on D
        add(0,1,0,1,8'h61,3, 8'hE5,1,8'hE5,1,3);
        add(0,1,0,1,8'h62,3, 8'hF6,0,8'hF6,0,3);
        add(0,1,0,1,8'h63,3, 8'h07,1,8'h07,1,4);
        add(0,1,0,1,8'h64,3, 8'h61,1,8'h61,1,4);
        add(0,1,1,1,8'h99,3, 8'h61,0,8'h61,0,0);
        add(0,1,0,0,8'h00,3, 8'h62,0,8'h62,0,0);
        add(0,1,0,0,8'h00,3, 8'h63,0,8'h63,0,0);
        add(0,1,0,0,8'h00,3, 8'h64,0,8'h64,0,0);
        add(0,1,0,0,8'h00,3, 8'h00,0,8'h00,0,0);
        // reset mid-stream
        add(0,1,0,1,8'h71,0, 8'h00,0,8'h71,1,1);
        add(0,1,0,1,8'h72,0, 8'h00,0,8'h72,1,2);
        add(0,1,0,1,8'h73,0, 8'h00,0,8'h73,1,3);
        add(1,1,0,1,8'h74,0, 8'h00,0,8'h00,0,0);
        for (int i = 0; i < 5; i++)
            add(0,1,0,0,8'h00,0, 8'h00,0,8'h00,0,0);

        @(posedge Clock);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            row = i;
            step(v.rst, v.en, v.fl, v.dv, v.d, v.ts);
            chk("q", bus.Q, v.q);
            chk("qvalid", bus.QValid, v.qv);
            chk("tapq", bus.TapQ, v.tq);
            chk("tapvalid", bus.TapValid, v.tv);
            chk("count", bus.Count, v.cnt);
            chk("full", bus.Full, v.cnt == 4);
            chk("empty", bus.Empty, v.cnt == 0);
            chk("parerr", bus.ParErr, 0);
        end
        row = -1;
        chk("sb_left", sb.size(), 0);

`ifdef SHIFT_PIPE_PARITY_EN
        // corrupt stored parity of 0xA5 (true even parity is 0)
        step(0,1,0,1,8'hA5,0);
        force u_dut.g_stage[0].u_stage.par_q = 1'b1;
        #1;
        release u_dut.g_stage[0].u_stage.par_q;
        step(0,1,0,0,8'h00,0);
        step(0,1,0,0,8'h00,0);
        step(0,1,0,0,8'h00,0);
        chk("par_qv", bus.QValid, 1);
        chk("par_pre", bus.ParErr, 0);
        step(0,1,0,0,8'h00,0);
        chk("par_set", bus.ParErr, 1);
        step(0,1,1,0,8'h00,0);
        chk("par_flush", bus.ParErr, 1);
        step(1,0,0,0,8'h00,0);
        chk("par_rst", bus.ParErr, 0);
`else
        step(0,1,0,1,8'hA5,0);
        for (int i = 0; i < 4; i++) step(0,1,0,0,8'h00,0);
        chk("par_off", bus.ParErr, 0);
`endif

        // DEPTH=3 instance: latency 3 and out-of-range tap
        Resetn = 0;
        @(posedge Clock);
        #1;
        Resetn = 1;
        bus3.En = 1;
        bus3.DValid = 1;
        for (int i = 0; i < 3; i++) begin
            bus3.D = 8'h31 + 8'(i);
            @(posedge Clock);
            #1;
        end
        bus3.En = 0;
        chk("d3_q", bus3.Q, 8'h31);
        chk("d3_qv", bus3.QValid, 1);
        chk("d3_full", bus3.Full, 1);
        bus3.TapSel = 2'd3;
        #1;
        chk("d3_tap3", bus3.TapQ, 0);
        chk("d3_tap3v", bus3.TapValid, 0);
        bus3.TapSel = 2'd1;
        #1;
        chk("d3_tap1", bus3.TapQ, 8'h32);
        chk("d3_tap1v", bus3.TapValid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_shift_pipe.md
Name: param_shift_pipe

Overview:
Parametrised successor to the team's two-stage D→Q1→Q2 flip-flop chain. It is a WIDTH-bit, DEPTH-stage shift pipeline with the following features:
- per-stage valid bits;
- global shift enable (stall);
- flush;
- selectable mid-pipe tap;
- occupancy counter.

It sits between a producer and a consumer wherever a fixed, known data delay with bubble tracking is required.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of register stages (>=2)
TAPW, $clog2(DEPTH), width of tap select (derived localparam, not overridable)
CNTW, $clog2(DEPTH+1), width of occupancy count (derived localparam)

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  synchronous active-low reset
En  input  1  shift enable; 0 = hold all stages
Flush  input  1  invalidate all stages
D  input  WIDTH  data into stage 0
DValid  input  1  D carries valid data
TapSel  input  TAPW  stage index driven onto TapQ
Q  output  WIDTH  data of stage DEPTH-1
QValid  output  1  valid bit of stage DEPTH-1
TapQ  output  WIDTH  data of stage TapSel
TapValid  output  1  valid bit of stage TapSel
Count  output  CNTW  number of valid stages
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
ParErr  output  1  sticky parity error (optional feature)

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low. Clock port is Clock, reset port is Resetn.
- Resetn=0 at a posedge clears all stage data, all valid bits, Count and ParErr. After reset: Q=0, QValid=0, TapQ=0, TapValid=0, Count=0, Full=0, Empty=1.
- Priority per posedge: Resetn > Flush > En > hold.
- Flush=1:
  - all valid bits and Count go to 0; stage data is retained.
  - D/DValid on that cycle are discarded, regardless of En.
- En=1, Flush=0:
  - stage0 <= {D, DValid};
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1;
  - the old stage[DEPTH-1] is dropped.
- En=0: every stage, valid bit and Count holds. DValid is ignored.
- Latency: a word captured on an En cycle appears on Q after DEPTH further... more precisely, it reaches Q after exactly DEPTH En-cycles counting the capture cycle. Stall cycles add delay 1:1.
- Count, when En=1:
  - Count_next = Count + DValid - QValid_old;
  - simultaneous entry and exit leaves Count unchanged;
  - Count never wraps (0..DEPTH by construction).
- Q/QValid/TapQ/TapValid are combinational reads of stage registers; there is no extra register stage.
- Full/Empty are decoded from the Count register.
- TapSel >= DEPTH (possible when DEPTH is not a power of two): TapQ=0, TapValid=0.
- Bubbles: DValid=0 words still shift. Their data field is D as presented; consumers must gate on the valid bit.
- Reset mid-stream discards all in-flight data; nothing is emitted after reset until new valid input arrives.

Optional Feature:
Macro SHIFT_PIPE_PARITY_EN.
- Defined:
  - each stage carries an extra even-parity bit computed from D at capture;
  - at stage DEPTH-1, if QValid=1 and recomputed parity differs from the stored bit, ParErr sets on the next posedge;
  - ParErr is sticky until Resetn=0; Flush does not clear it.
- Undefined: no parity storage; ParErr tied to 0. The port list is identical in both builds.

Decomposition:
- Package shift_pipe_pkg holds:
  - function clog2_min1 (returns >=1);
  - typedef for a stage record {logic valid; logic par; logic [WIDTH-1:0] data} as a parametrised struct helper;
  - localparam defaults for WIDTH/DEPTH.
- One sub-module, shift_pipe_stage: a single registered stage with inputs for enable, flush, reset and the previous stage, instantiated DEPTH times in a generate loop.
- Count logic, tap mux and parity check live in the top level.

Test Plan:
1. Reset, then stream 0x11,0x22,0x33,0x44,0x55 with En=1, DValid=1 (WIDTH=8, DEPTH=4) → Q=0x11 with QValid=1 on the 4th edge after the first capture. Count reads 1,2,3,4,4; Full=1 from the 4th edge.
2. Fill with 4 words, then hold En=0 for 3 cycles → Q, TapQ and Count unchanged. Resume with En=1 → words exit in order, and Count decrements when DValid=0 is fed.
3. Alternate DValid 1/0 with En=1 → QValid toggles 1/0 at the output. Count settles at 2; TapSel=1 shows the correct stage-1 data and valid bit.
4. Pipe full, assert Flush together with En=1, DValid=1, D=0x99 → next edge: Count=0, Empty=1, all valid bits 0, and 0x99 is never emitted.
5. Assert Resetn=0 for one edge mid-stream with 3 valid words → all outputs 0, Empty=1. No stale word appears on Q afterwards.
6. With SHIFT_PIPE_PARITY_EN, force the parity bit of stage 0 flipped on word 0xA5 → ParErr=1 one edge after the word reaches Q, and it stays 1 through a Flush. Without the macro, ParErr stays 0.
